// File: rtl/load_counter_arbiter.sv
// rtl/load_counter_arbiter.sv - one reloadable up-counter shared by NUM_REQ requesters.
// Round-robin by default; define FIXED_PRIO_EN for fixed lowest-index-wins priority.
module load_counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_val,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   start_q, start_d;
  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [CNT_W-1:0]   win_val;
  logic               winner_left;

`ifndef FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]    rr_adv;

  assign rr_adv = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
`endif

  // Search order starts at rr_ptr (or at 0 with fixed priority); first active request wins.
  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_l;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    idx_l  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FIXED_PRIO_EN
      idx = i;
`else
      idx = (int'(rr_ptr) + i) % NUM_REQ;
`endif
      idx_l = ID_W'(idx);
      if (!found && req[idx_l]) begin
        found  = 1'b1;
        win_id = idx_l;
      end
    end
  end

  always_comb begin
    win_val = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (win_id == ID_W'(n)) win_val = req_val[n*CNT_W +: CNT_W];
    end
  end

  assign winner_left = !req[gnt_id];

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    count_d  = count;
    start_d  = start_q;
`ifndef FIXED_PRIO_EN
    rr_ptr_d = rr_ptr;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_d    = NUM_REQ'(1) << win_id;
          gnt_id_d = win_id;
          start_d  = win_val;
          state_d  = S_LOAD;
        end
      end
      S_LOAD, S_RUN: begin
        // An abandoned run ends silently and still moves the round-robin pointer on.
        if (winner_left) begin
          gnt_d   = '0;
          state_d = S_IDLE;
`ifndef FIXED_PRIO_EN
          rr_ptr_d = rr_adv;
`endif
        end else if (state == S_LOAD) begin
          count_d = start_q;
          state_d = S_RUN;
        end else if (count == MAX) begin
          state_d = S_DONE;
        end else begin
          count_d = count + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
`ifndef FIXED_PRIO_EN
        rr_ptr_d = rr_adv;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      count   <= '0;
      start_q <= '0;
`ifndef FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      count   <= count_d;
      start_q <= start_d;
`ifndef FIXED_PRIO_EN
      rr_ptr  <= rr_ptr_d;
`endif
    end
  end

  // gnt is one-hot on the winner, so gating it by DONE gives the single done pulse.
  assign done = (state == S_DONE) ? gnt : '0;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_load_counter_arbiter.sv
// tb/tb_load_counter_arbiter.sv - scoreboard bench for load_counter_arbiter.
module tb_load_counter_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req;
  logic [15:0] req_val;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] id;
    logic [3:0] val;
    logic [7:0] len;
  } ev_t;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  ev_t exp_q[$];

  load_counter_arbiter #(.NUM_REQ(4), .CNT_W(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_val(req_val),
    .gnt(gnt), .gnt_id(gnt_id), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int k, input int id, input int v, input int len);
    ev_t e;
    e.kind = 2'(k);
    e.id   = 2'(id);
    e.val  = 4'(v);
    e.len  = 8'(len);
    exp_q.push_back(e);
  endtask

  task automatic get_ev(output ev_t e);
    e = '0;
    chk("event_expected", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  // kind 0: done[i]; kind 1: gnt[i]; kind 2: count == i
  task automatic wait_sig(input int kind, input int i);
    bit hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      case (kind)
        0: hit = done[i];
        1: hit = gnt[i];
        default: hit = (int'(count) == i);
      endcase
    end
    chk("wait_bound", 32'(hit), 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {21'd0, gnt, gnt_id, done, busy, count}, 0);
  endtask

  // Monitor: turns DUT output activity into events and scores them against exp_q.
  int         cyc = 0;
  int         grant_cyc = 0;
  logic [3:0] prev_gnt = '0;
  logic       prev_done = 1'b0;
  logic       load_pending = 1'b0;
  logic       after_done = 1'b0;
  logic [3:0] exp_start = '0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (reset) begin
      prev_gnt     = '0;
      prev_done    = 1'b0;
      load_pending = 1'b0;
      after_done   = 1'b0;
    end else begin
      if (gnt != 0 && prev_gnt == 0) begin
        get_ev(e);
        chk("grant_kind", 32'(e.kind), EV_GRANT);
        chk("grant_id", 32'(gnt_id), 32'(e.id));
        chk("grant_onehot", 32'(gnt), 32'(4'b0001 << e.id));
        exp_start    = e.val;
        load_pending = 1'b1;
        grant_cyc    = cyc;
      end else if (load_pending) begin
        chk("load_count", 32'(count), 32'(exp_start));
        load_pending = 1'b0;
      end
      if (done != 0) begin
        get_ev(e);
        chk("done_kind", 32'(e.kind), EV_DONE);
        chk("done_vec", 32'(done), 32'(4'b0001 << e.id));
        chk("done_count", 32'(count), 32'hF);
        chk("run_len", 32'(cyc - grant_cyc), 32'(e.len));
        after_done = 1'b1;
      end else if (after_done) begin
        chk("idle_after_done", {29'd0, busy, |gnt, |done}, 0);
        after_done = 1'b0;
      end
      if (gnt == 0 && prev_gnt != 0 && !prev_done) begin
        get_ev(e);
        chk("abort_kind", 32'(e.kind), EV_ABORT);
        chk("abort_id", 32'(gnt_id), 32'(e.id));
      end
      prev_gnt  = gnt;
      prev_done = |done;
    end
  end

  int ids[5];

  initial begin
    req     = '0;
    req_val = '0;

    #2 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    @(posedge clk) #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("idle_after_reset");

    // single request, start 0xC
    req_val = 16'h00C0;
    push(EV_GRANT, 1, 12, 0);
    push(EV_DONE, 1, 0, 5);
    req = 4'b0010;
    wait_sig(0, 1);
    req = '0;
    repeat (2) @(negedge clk);
    chk("busy_after_single", 32'(busy), 0);

    // all four requesting, fresh pointer
    @(posedge clk) #2 reset = 1'b1;
    @(negedge clk);
    @(posedge clk) #2 reset = 1'b0;
`ifdef FIXED_PRIO_EN
    ids = '{0, 0, 0, 0, 0};
`else
    ids = '{0, 1, 2, 3, 0};
`endif
    req_val = 16'hEEEE;
    for (int k = 0; k < 5; k++) begin
      push(EV_GRANT, ids[k], 14, 0);
      push(EV_DONE, ids[k], 0, 3);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_sig(0, ids[k]);
    req = '0;
    repeat (2) @(negedge clk);

    // boundary start values
    req_val = 16'h000F;
    push(EV_GRANT, 0, 15, 0);
    push(EV_DONE, 0, 0, 2);
    req = 4'b0001;
    wait_sig(0, 0);
    req = '0;
    repeat (2) @(negedge clk);
    req_val = 16'h0000;
    push(EV_GRANT, 0, 0, 0);
    push(EV_DONE, 0, 0, 17);
    req = 4'b0001;
    wait_sig(0, 0);
    req = '0;
    repeat (2) @(negedge clk);

    // abort by winner 1, requester 2 takes over
    req_val = 16'h0D40;
    push(EV_GRANT, 1, 4, 0);
    push(EV_ABORT, 1, 0, 0);
    push(EV_GRANT, 2, 13, 0);
    push(EV_DONE, 2, 0, 4);
    req = 4'b0110;
    wait_sig(1, 1);
    repeat (3) @(negedge clk);
    req = 4'b0100;
    wait_sig(0, 2);
    req = '0;
    repeat (2) @(negedge clk);

    // reset during a run
    req_val = 16'h0005;
    push(EV_GRANT, 0, 5, 0);
    req = 4'b0001;
    wait_sig(2, 9);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid_run");
    req = '0;
    @(negedge clk);
    @(posedge clk) #2 reset = 1'b0;

    // pointer back at 0: requester 1 wins over 3
    req_val = 16'hE0E0;
    push(EV_GRANT, 1, 14, 0);
    push(EV_DONE, 1, 0, 3);
    req = 4'b1010;
    wait_sig(0, 1);
    req = '0;
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
